// File: rtl/idex_reg.sv
// idex_reg: ID/EX pipeline register with load-use hazard detection,
// registered forwarding selects and a saturating stall counter.
// Build option: IDEX_FORW_PRECOMPUTE_EN. When it is defined, forwarding
// selects are precomputed and only load-use hazards stall. When it is
// undefined, the selects are tied to 00 and any RAW match against EX or
// EX/MEM stalls the pipeline instead.
module idex_reg #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   id_valid_i,
  input  logic [6:0]             id_op_i,
  input  logic [4:0]             id_rs1_i,
  input  logic [4:0]             id_rs2_i,
  input  logic [4:0]             id_rd_i,
  input  logic                   id_reg_write_i,
  input  logic [31:0]            id_data1_i,
  input  logic [31:0]            id_data2_i,
  input  logic [31:0]            id_sdata_i,
  input  logic [31:0]            id_pc_i,
  input  logic [4:0]             exmem_rd_i,
  input  logic                   exmem_reg_write_i,
  output logic                   stall_o,
  output logic                   ex_valid_o,
  output logic                   ex_reg_write_o,
  output logic [6:0]             ex_op_o,
  output logic [4:0]             ex_rd_o,
  output logic [31:0]            ex_data1_o,
  output logic [31:0]            ex_data2_o,
  output logic [31:0]            ex_sdata_o,
  output logic [31:0]            ex_pc_o,
  output logic [1:0]             ex_forwA_o,
  output logic [1:0]             ex_forwB_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic                   valid_q, valid_d;
  logic                   reg_write_q, reg_write_d;
  logic [6:0]             op_q, op_d;
  logic [4:0]             rd_q, rd_d;
  logic [31:0]            data1_q, data1_d;
  logic [31:0]            data2_q, data2_d;
  logic [31:0]            sdata_q, sdata_d;
  logic [31:0]            pc_q, pc_d;
  logic [1:0]             forw_a_q, forw_a_d;
  logic [1:0]             forw_b_q, forw_b_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic use_rs1, use_rs2;
  logic ex_prod, mem_prod;
  logic rs1_hit_ex, rs2_hit_ex, rs1_hit_mem, rs2_hit_mem;
  logic hazard, stall, bubble;

  // Decode which source specifiers the ID instruction actually reads.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (id_op_i)
      OP_R, OP_STORE, OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  // A producer never matches x0, so a nonzero rd makes the rs != 0 test implicit.
  assign ex_prod     = valid_q & reg_write_q & (rd_q != 5'd0);
  assign mem_prod    = exmem_reg_write_i & (exmem_rd_i != 5'd0);
  assign rs1_hit_ex  = use_rs1 & ex_prod & (id_rs1_i == rd_q);
  assign rs2_hit_ex  = use_rs2 & ex_prod & (id_rs2_i == rd_q);
  assign rs1_hit_mem = use_rs1 & mem_prod & (id_rs1_i == exmem_rd_i);
  assign rs2_hit_mem = use_rs2 & mem_prod & (id_rs2_i == exmem_rd_i);

`ifdef IDEX_FORW_PRECOMPUTE_EN
  assign hazard = (op_q == OP_LOAD) & (rs1_hit_ex | rs2_hit_ex);
`else
  assign hazard = rs1_hit_ex | rs2_hit_ex | rs1_hit_mem | rs2_hit_mem;
`endif

  assign stall   = id_valid_i & hazard & ~flush_i & ~rst_i;
  assign bubble  = flush_i | stall | ~id_valid_i;
  assign stall_o = stall;

  // Next-state: bubble by default, latch the ID fields when nothing blocks them.
  always_comb begin
    valid_d     = 1'b0;
    reg_write_d = 1'b0;
    op_d        = 7'd0;
    rd_d        = 5'd0;
    data1_d     = 32'd0;
    data2_d     = 32'd0;
    sdata_d     = 32'd0;
    pc_d        = 32'd0;
    forw_a_d    = 2'b00;
    forw_b_d    = 2'b00;
    if (!bubble) begin
      valid_d     = 1'b1;
      reg_write_d = id_reg_write_i;
      op_d        = id_op_i;
      rd_d        = id_rd_i;
      data1_d     = id_data1_i;
      data2_d     = id_data2_i;
      sdata_d     = id_sdata_i;
      pc_d        = id_pc_i;
`ifdef IDEX_FORW_PRECOMPUTE_EN
      forw_a_d    = rs1_hit_ex ? 2'b01 : (rs1_hit_mem ? 2'b10 : 2'b00);
      forw_b_d    = rs2_hit_ex ? 2'b01 : (rs2_hit_mem ? 2'b10 : 2'b00);
`endif
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != {STALL_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Pipeline register and stall counter with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      op_q        <= 7'd0;
      rd_q        <= 5'd0;
      data1_q     <= 32'd0;
      data2_q     <= 32'd0;
      sdata_q     <= 32'd0;
      pc_q        <= 32'd0;
      forw_a_q    <= 2'b00;
      forw_b_q    <= 2'b00;
      cnt_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      sdata_q     <= sdata_d;
      pc_q        <= pc_d;
      forw_a_q    <= forw_a_d;
      forw_b_q    <= forw_b_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ex_valid_o     = valid_q;
  assign ex_reg_write_o = reg_write_q;
  assign ex_op_o        = op_q;
  assign ex_rd_o        = rd_q;
  assign ex_data1_o     = data1_q;
  assign ex_data2_o     = data2_q;
  assign ex_sdata_o     = sdata_q;
  assign ex_pc_o        = pc_q;
  assign ex_forwA_o     = forw_a_q;
  assign ex_forwB_o     = forw_b_q;
  assign stall_cnt_o    = cnt_q;

endmodule

// File: tb/tb_idex_reg.sv
// Testbench for idex_reg: directed scenarios plus random instruction stream,
// checked against a pipeline-level reference model.
module tb_idex_reg;

  localparam int W      = 4;
  localparam int CNT_MAX = (1 << W) - 1;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] IMM = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JLR = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] AUI = 7'b0010111;
  localparam logic [6:0] JAL = 7'b1101111;

`ifdef IDEX_FORW_PRECOMPUTE_EN
  localparam int EXP_RAW = 0;
  localparam int EXP_LU  = 1;
  localparam int EXP_SW  = 0;
  localparam int EXP_FA_RAW = 1;
  localparam int EXP_FA_LU  = 2;
  localparam int EXP_FB_SW  = 2;
`else
  localparam int EXP_RAW = 2;
  localparam int EXP_LU  = 2;
  localparam int EXP_SW  = 1;
  localparam int EXP_FA_RAW = 0;
  localparam int EXP_FA_LU  = 0;
  localparam int EXP_FB_SW  = 0;
`endif

  typedef struct {
    logic v; logic [6:0] op; logic [4:0] rs1, rs2, rd; logic rw;
    logic [31:0] d1, d2, sd, pc;
  } instr_t;

  typedef struct {
    logic v, rw; logic [6:0] op; logic [4:0] rd;
    logic [31:0] d1, d2, sd, pc; logic [1:0] fa, fb;
  } ex_t;

  logic clk_i = 1'b0;
  logic rst_i, flush_i, id_valid_i, id_reg_write_i, exmem_reg_write_i;
  logic [6:0] id_op_i;
  logic [4:0] id_rs1_i, id_rs2_i, id_rd_i, exmem_rd_i;
  logic [31:0] id_data1_i, id_data2_i, id_sdata_i, id_pc_i;
  logic stall_o, ex_valid_o, ex_reg_write_o;
  logic [6:0] ex_op_o;
  logic [4:0] ex_rd_o;
  logic [31:0] ex_data1_o, ex_data2_o, ex_sdata_o, ex_pc_o;
  logic [1:0] ex_forwA_o, ex_forwB_o;
  logic [W-1:0] stall_cnt_o;

  int n_assert = 0;
  int n_fail   = 0;
  ex_t m_ex, m_prev;
  int m_cnt;

  idex_reg #(.STALL_CNT_W(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
    .id_op_i(id_op_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_reg_write_i(id_reg_write_i), .id_data1_i(id_data1_i), .id_data2_i(id_data2_i),
    .id_sdata_i(id_sdata_i), .id_pc_i(id_pc_i), .exmem_rd_i(exmem_rd_i),
    .exmem_reg_write_i(exmem_reg_write_i), .stall_o(stall_o), .ex_valid_o(ex_valid_o),
    .ex_reg_write_o(ex_reg_write_o), .ex_op_o(ex_op_o), .ex_rd_o(ex_rd_o),
    .ex_data1_o(ex_data1_o), .ex_data2_o(ex_data2_o), .ex_sdata_o(ex_sdata_o),
    .ex_pc_o(ex_pc_o), .ex_forwA_o(ex_forwA_o), .ex_forwB_o(ex_forwB_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit uses_src(logic [6:0] op, int which);
    if (which == 1) return op inside {R, IMM, LD, ST, BR, JLR};
    return op inside {R, ST, BR};
  endfunction

  function automatic bit reads_reg(instr_t i, logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    return (uses_src(i.op, 1) && i.rs1 == r) || (uses_src(i.op, 2) && i.rs2 == r);
  endfunction

`ifdef IDEX_FORW_PRECOMPUTE_EN
  function automatic logic [1:0] fsel(bit used, logic [4:0] r);
    if (!used || r == 5'd0) return 2'b00;
    if (m_ex.v && m_ex.rw && m_ex.rd == r) return 2'b01;
    if (m_prev.v && m_prev.rw && m_prev.rd == r) return 2'b10;
    return 2'b00;
  endfunction
`endif

  function automatic instr_t mk(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                                logic [4:0] rs2, logic rw);
    instr_t i;
    i.v = 1'b1; i.op = op; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.rw = rw;
    i.d1 = $urandom; i.d2 = $urandom; i.sd = $urandom; i.pc = $urandom;
    return i;
  endfunction

  function automatic instr_t rnd_instr();
    logic [6:0] ops [0:8];
    instr_t i;
    ops = '{R, IMM, LD, ST, BR, JLR, LUI, AUI, JAL};
    i = mk(ops[$urandom % 9], 5'($urandom % 4), 5'($urandom % 4), 5'($urandom % 4), 1'b0);
    i.v = ($urandom % 10) != 0;
    if (i.op inside {ST, BR}) i.rw = 1'b0;
    else if (i.op == LD)      i.rw = 1'b1;
    else                      i.rw = ($urandom % 4) != 0;
    return i;
  endfunction

  // One clock: drive ID/EX-MEM inputs, check stall, clock, check registered outputs.
  task automatic cycle(input instr_t id, input logic fl, input logic r, output bit st);
    ex_t nx;
    bit p_ex, p_mem, hz;
    rst_i = r; flush_i = fl;
    id_valid_i = id.v; id_op_i = id.op; id_rs1_i = id.rs1; id_rs2_i = id.rs2;
    id_rd_i = id.rd; id_reg_write_i = id.rw; id_data1_i = id.d1; id_data2_i = id.d2;
    id_sdata_i = id.sd; id_pc_i = id.pc;
    exmem_rd_i = m_prev.rd; exmem_reg_write_i = m_prev.v & m_prev.rw;
    #1;
    p_ex  = m_ex.v && m_ex.rw && reads_reg(id, m_ex.rd);
    p_mem = m_prev.v && m_prev.rw && reads_reg(id, m_prev.rd);
`ifdef IDEX_FORW_PRECOMPUTE_EN
    hz = p_ex && (m_ex.op == LD);
`else
    hz = p_ex || p_mem;
`endif
    st = id.v && hz && !fl && !r;
    chk("stall", 32'(stall_o), 32'(st));
    nx = '{v: 1'b0, rw: 1'b0, op: 7'd0, rd: 5'd0, d1: 32'd0, d2: 32'd0, sd: 32'd0,
           pc: 32'd0, fa: 2'b00, fb: 2'b00};
    if (!r && !fl && !st && id.v) begin
      nx.v = 1'b1; nx.rw = id.rw; nx.op = id.op; nx.rd = id.rd;
      nx.d1 = id.d1; nx.d2 = id.d2; nx.sd = id.sd; nx.pc = id.pc;
`ifdef IDEX_FORW_PRECOMPUTE_EN
      nx.fa = fsel(uses_src(id.op, 1), id.rs1);
      nx.fb = fsel(uses_src(id.op, 2), id.rs2);
`endif
    end
    if (r) m_cnt = 0;
    else if (st && m_cnt < CNT_MAX) m_cnt++;
    @(posedge clk_i);
    #1;
    m_prev = r ? nx : m_ex;
    m_ex = nx;
    chk("ex_valid", 32'(ex_valid_o), 32'(m_ex.v));
    chk("ex_reg_write", 32'(ex_reg_write_o), 32'(m_ex.rw));
    chk("ex_op", 32'(ex_op_o), 32'(m_ex.op));
    chk("ex_rd", 32'(ex_rd_o), 32'(m_ex.rd));
    chk("ex_data1", ex_data1_o, m_ex.d1);
    chk("ex_data2", ex_data2_o, m_ex.d2);
    chk("ex_sdata", ex_sdata_o, m_ex.sd);
    chk("ex_pc", ex_pc_o, m_ex.pc);
    chk("ex_forwA", 32'(ex_forwA_o), 32'(m_ex.fa));
    chk("ex_forwB", 32'(ex_forwB_o), 32'(m_ex.fb));
    chk("stall_cnt", 32'(stall_cnt_o), 32'(m_cnt));
  endtask

  // Present an instruction until it is accepted; returns the number of stall cycles.
  task automatic issue(input instr_t i, output int ns);
    bit st;
    ns = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(i, 1'b0, 1'b0, st);
      if (!st) return;
      ns++;
    end
    chk("issue_bound", 32'(ns), 32'd0);
  endtask

  instr_t nop, cur;
  int ns;
  bit st;

  initial begin
    m_ex = '{v: 1'b0, rw: 1'b0, op: 7'd0, rd: 5'd0, d1: 32'd0, d2: 32'd0, sd: 32'd0,
             pc: 32'd0, fa: 2'b00, fb: 2'b00};
    m_prev = m_ex;
    m_cnt = 0;
    nop = mk(7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    nop.v = 1'b0;

    // Reset for two cycles.
    cycle(nop, 1'b0, 1'b1, st);
    cycle(nop, 1'b0, 1'b1, st);
    cycle(nop, 1'b0, 1'b0, st);

    // add x5,x1,x2 ; sub x6,x5,x3
    issue(mk(R, 5'd5, 5'd1, 5'd2, 1'b1), ns);
    issue(mk(R, 5'd6, 5'd5, 5'd3, 1'b1), ns);
    chk("raw_stalls", 32'(ns), 32'(EXP_RAW));
    chk("raw_forwA", 32'(ex_forwA_o), 32'(EXP_FA_RAW));
    chk("raw_forwB", 32'(ex_forwB_o), 32'd0);
    issue(nop, ns); issue(nop, ns);

    // lw x7,0(x1) ; add x8,x7,x7
    issue(mk(LD, 5'd7, 5'd1, 5'd0, 1'b1), ns);
    issue(mk(R, 5'd8, 5'd7, 5'd7, 1'b1), ns);
    chk("lu_stalls", 32'(ns), 32'(EXP_LU));
    chk("lu_forwA", 32'(ex_forwA_o), 32'(EXP_FA_LU));
    chk("lu_forwB", 32'(ex_forwB_o), 32'(EXP_FA_LU));
    issue(nop, ns); issue(nop, ns);

    // addi x9 ; addi x10 ; sw x9,4(x2)
    issue(mk(IMM, 5'd9, 5'd1, 5'd0, 1'b1), ns);
    issue(mk(IMM, 5'd10, 5'd0, 5'd0, 1'b1), ns);
    issue(mk(ST, 5'd0, 5'd2, 5'd9, 1'b0), ns);
    chk("sw_stalls", 32'(ns), 32'(EXP_SW));
    chk("sw_forwB", 32'(ex_forwB_o), 32'(EXP_FB_SW));
    chk("sw_forwA", 32'(ex_forwA_o), 32'd0);
    issue(nop, ns); issue(nop, ns);

    // Flush while a load-use stall would occur.
    issue(mk(LD, 5'd7, 5'd1, 5'd0, 1'b1), ns);
    cycle(mk(R, 5'd8, 5'd7, 5'd7, 1'b1), 1'b1, 1'b0, st);
    issue(nop, ns); issue(nop, ns);

    // Write to x0 then read x0: never a hazard.
    issue(mk(IMM, 5'd0, 5'd1, 5'd0, 1'b1), ns);
    issue(mk(R, 5'd11, 5'd0, 5'd0, 1'b1), ns);
    chk("x0_stalls", 32'(ns), 32'd0);
    issue(nop, ns); issue(nop, ns);

    // Same rd in EX and EX/MEM: the younger producer wins.
    issue(mk(IMM, 5'd5, 5'd1, 5'd0, 1'b1), ns);
    issue(mk(IMM, 5'd5, 5'd2, 5'd0, 1'b1), ns);
    issue(mk(R, 5'd12, 5'd5, 5'd0, 1'b1), ns);

    // Random stream with occasional flush and reset.
    cur = rnd_instr();
    for (int k = 0; k < 600; k++) begin
      cycle(cur, 1'b0 + (($urandom % 10) == 0), 1'b0 + (($urandom % 60) == 0), st);
      if (!st) cur = rnd_instr();
    end

    // Saturate the stall counter.
    for (int k = 0; k < 20; k++) begin
      issue(mk(LD, 5'd7, 5'd1, 5'd0, 1'b1), ns);
      issue(mk(R, 5'd8, 5'd7, 5'd1, 1'b1), ns);
    end
    chk("cnt_saturated", 32'(stall_cnt_o), 32'(CNT_MAX));

    // Reset while a hazard is pending.
    issue(mk(LD, 5'd7, 5'd1, 5'd0, 1'b1), ns);
    cycle(mk(R, 5'd8, 5'd7, 5'd7, 1'b1), 1'b0, 1'b1, st);
    chk("rst_cnt", 32'(stall_cnt_o), 32'd0);
    chk("rst_valid", 32'(ex_valid_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/idex_reg.md
# idex_reg

ID/EX pipeline register with built-in hazard detection for the 5-stage RV32I core. It latches decoded ID-stage fields every cycle and detects load-use hazards, stalling IF/ID and inserting a bubble when one occurs. It pre-computes the `forwA`/`forwB` select codes one cycle ahead, so the EX-stage forwarding unit receives registered selects aligned with `ex_data1`/`ex_data2`/`ex_sdata`. Branch flushes from EX squash the instruction being latched.

## Interface
Parameters:
- `STALL_CNT_W`, 16: width of the saturating stall performance counter.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: taken branch/jump resolved in EX; squash the ID instruction.
- `id_valid` in 1: ID holds a real instruction.
- `id_op` in 7: opcode of the ID instruction.
- `id_rs1`, `id_rs2`, `id_rd` in 5 each: register specifiers.
- `id_reg_write` in 1: the ID instruction writes `rd`.
- `id_data1`, `id_data2`, `id_sdata`, `id_pc` in 32 each: rs1 value; operand2 (imm for I/S, rs2 otherwise); rs2 store value; PC.
- `exmem_rd` in 5, `exmem_reg_write` in 1: destination of the instruction currently in EX/MEM.
- `stall` out 1: combinational; hold PC and IF/ID this cycle.
- `ex_valid`, `ex_reg_write` out 1 each: registered.
- `ex_op` out 7, `ex_rd` out 5: registered.
- `ex_data1`, `ex_data2`, `ex_sdata`, `ex_pc` out 32: registered.
- `ex_forwA`, `ex_forwB` out 2: registered select codes. 00 = register value, 01 = EX/MEM result, 10 = MEM/WB result; 11 is never produced.
- `stall_cnt` out `STALL_CNT_W`: saturating count of stall cycles.

## Operation
Operand usage:
- rs1 used by R, I_IMM, I_LOAD, S, B, I_JALR.
- rs2 used by R, S, B.
- LUI, AUIPC and JAL use neither.
- A specifier of x0 never matches.
- A hazard requires the producer to be valid with `reg_write=1`.

Load-use hazard:
- Condition: `ex_valid`, `ex_op==I_LOAD` (0000011), `ex_rd!=0`, and `ex_rd` equals a used rs of the valid ID instruction.
- Response: `stall=1`. The next edge loads a bubble: `ex_valid=0`, `ex_reg_write=0`, `ex_rd=0`, `ex_op=0`, data 0, forw 00. The ID instruction is re-presented the following cycle.

Forward select, computed per used rs at latch time, highest priority first:
- Current `ex_rd` (becomes EX/MEM next cycle) with valid and `ex_reg_write` -> 01. This case is never a load, because a load match stalls instead.
- Else `exmem_rd` with `exmem_reg_write` -> 10.
- Else 00.
- An unused rs always gets 00.
- The register file is write-first, so WB-to-ID needs no forwarding.

Control priority:
- `rst` > `flush` > `stall` > normal latch.
- When `flush=1`: `stall` is forced to 0, a bubble is latched, and `stall_cnt` is not incremented.
- When `id_valid=0`: a bubble is latched and `stall` is 0.

Stall counter:
- Increments on every cycle with `stall=1`.
- Holds at all-ones.
- Cleared only by `rst`.

## Timing
- Latency: one cycle, ID inputs to `ex_*` outputs.
- `stall` is combinational from `ex_*` registers and ID inputs, within the same cycle.
- A load-use hazard costs exactly one bubble. On the next cycle the load is in EX/MEM, and the consumer latches with select 10.
- Reset values: all `ex_*` = 0, `ex_forwA`/`ex_forwB` = 00, `stall_cnt` = 0. `stall` is 0 while `ex_valid=0`.
- `rst` asserted mid-stall: on the next edge the pipeline is empty and the counter is cleared.
- Simultaneous match on `ex_rd` and `exmem_rd`: 01 wins.

## Configuration
`IDEX_FORW_PRECOMPUTE_EN`:
- Defined: behaviour as above; the forwarding unit runs with forwarding on.
- Undefined: `ex_forwA`/`ex_forwB` are tied to 00. `stall` asserts for any used-rs match against valid writing `ex_rd` or `exmem_rd`, not only loads. Back-to-back RAW therefore costs 2 bubbles.

## Test plan
- Reset: `rst` for 2 cycles -> all outputs 0, `stall=0`.
- `add x5,x1,x2` then `sub x6,x5,x3` (R, 0110011) -> sub latched with `ex_forwA=01`, `ex_forwB=00`, no stall.
- `lw x7,0(x1)` then `add x8,x7,x7` -> one cycle with `stall=1` and a bubble. Then add latched with forwA=forwB=10, and `stall_cnt=1`.
- `sw x9,4(x2)` two instructions after `addi x9,...` -> `ex_forwB=10` (rs2), `ex_forwA=00`.
- `flush` during a load-use stall -> `stall=0`, bubble latched, `stall_cnt` unchanged.
- Write to x0 followed by a reader of x0 -> forw 00, no stall. With the macro undefined, the back-to-back RAW case gives 2 stall cycles.
